shift_sequencer: RTL

//  Iterative shift/rotate engine for the SHA-256 round datapath. Accepts one 32-bit word plus
//  op/amount over a valid/ready handshake and shifts it one bit position per clock through a

---
 rtl/shift_pkg.sv | 19 +
 rtl/single_bit_shift_stage.sv | 25 ++
 rtl/shift_sequencer.sv | 84 ++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// Shared encodings for the iterative shift sequencer: operation codes, FSM states
// and the default word geometry used by the SHA-256 round datapath.
package shift_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_AMT_W = 5;

    localparam logic [1:0] SHIFT_OP_SHL  = 2'b00;
    localparam logic [1:0] SHIFT_OP_SHR  = 2'b01;
    localparam logic [1:0] SHIFT_OP_ROTR = 2'b10;
    localparam logic [1:0] SHIFT_OP_ROTL = 2'b11;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'b00,
        SEQ_SHIFT = 2'b01,
        SEQ_DONE  = 2'b10
    } seqState_e;

endpackage

// File: rtl/single_bit_shift_stage.sv
// Combinational one-position shift/rotate of a data word; the sequencer applies it
// once per clock to build up the requested amount.
module single_bit_shift_stage
    import shift_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] q
);

    always_comb begin
        // NOTE: assign a default before the case so no path leaves q unassigned and infers a latch.
        q = d;
        case (op)
            SHIFT_OP_SHL:  q = {d[WIDTH-2:0], 1'b0};
            SHIFT_OP_SHR:  q = {1'b0, d[WIDTH-1:1]};
            SHIFT_OP_ROTR: q = {d[0], d[WIDTH-1:1]};
            SHIFT_OP_ROTL: q = {d[WIDTH-2:0], d[WIDTH-1]};
            default:       q = d;
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Iterative shift/rotate engine: accepts a word over valid/ready, shifts it one bit per
// clock through a single-bit stage, and presents the result until the consumer takes it.
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int AMT_W = DEFAULT_AMT_W
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [AMT_W-1:0] in_amt,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    seqState_e        state;
    logic [WIDTH-1:0] dataQ;
    logic [AMT_W-1:0] countQ;
    logic [1:0]       opQ;
    logic [WIDTH-1:0] stepped;
    logic             acceptReq;

    single_bit_shift_stage #(.WIDTH(WIDTH)) uStage (
        .d  (dataQ),
        .op (opQ),
        .q  (stepped)
    );

    // A finished result may be replaced by the next request on the edge it is consumed.
    assign in_ready  = ((state == SEQ_IDLE) || ((state == SEQ_DONE) && out_ready)) && !flush;
    assign acceptReq = in_valid && in_ready;

    assign out_valid = (state == SEQ_DONE);
    assign busy      = (state != SEQ_IDLE);
    assign out_data  = dataQ;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state  <= SEQ_IDLE;
            dataQ  <= '0;
            countQ <= '0;
            opQ    <= SHIFT_OP_SHL;
        end else if (flush) begin
            state  <= SEQ_IDLE;
            countQ <= '0;
        end else if (acceptReq) begin
            dataQ  <= in_data;
            opQ    <= in_op;
            countQ <= in_amt;
            // Zero-amount requests still pass through SHIFT once (without stepping),
            // so every result appears at least one edge after acceptance.
            state  <= SEQ_SHIFT;
        end else begin
            case (state)
                SEQ_SHIFT: begin
                    if (countQ != '0) begin
                        dataQ  <= stepped;
                        countQ <= countQ - AMT_W'(1);
                    end
                    if (countQ <= AMT_W'(1)) begin
                        state <= SEQ_DONE;
                    end
                end
                SEQ_DONE: begin
                    if (out_ready) begin
                        state <= SEQ_IDLE;
                    end
                end
                default: begin
                    state <= SEQ_IDLE;
                end
            endcase
        end
    end

endmodule
